// File: rtl/mpu6050_seq_ctrl.sv
// MPU6050 sequencer: power-up wait, register init, periodic 14-byte burst reads.
// Define MPU_WHOAMI_CHECK_EN to verify WHO_AM_I (0x75) before init.
module mpu6050_seq_ctrl #(
    parameter logic [6:0] DEV_ADDR    = 7'h68,
    parameter int         PWRUP_CYC   = 1200000,
    parameter int         SAMPLE_DIV  = 120000,
    parameter int         RETRY_MAX   = 3,
    parameter int         TIMEOUT_CYC = 4095
) (
    input  logic        sys_clk_12m,
    input  logic        rst,
    input  logic        restart,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_rw,
    output logic [6:0]  cmd_dev_addr,
    output logic [7:0]  cmd_reg_addr,
    output logic [7:0]  cmd_wdata,
    input  logic        rsp_valid,
    input  logic        rsp_nack,
    input  logic [7:0]  rsp_data,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic [15:0] temp,
    output logic [15:0] gyro_x,
    output logic [15:0] gyro_y,
    output logic [15:0] gyro_z,
    output logic        sample_valid,
    output logic        init_done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        overrun
);

    typedef enum logic [3:0] {
        S_PWRUP, S_WHO_ISSUE, S_WHO_WAIT, S_INIT_ISSUE, S_INIT_WAIT,
        S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_PUBLISH, S_ERROR
    } state_t;

    state_t      state, wait_st, issue_st;
    logic [31:0] pwr_cnt, samp_cnt, tmo_cnt;
    logic [7:0]  retry_cnt;
    logic [3:0]  idx;
    logic [7:0]  shadow [0:12];
    logic        tick;

    assign cmd_dev_addr = DEV_ADDR;
    assign tick = init_done && (samp_cnt == 32'(SAMPLE_DIV - 1));

    function automatic logic [7:0] init_reg(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h6B;
            4'd1:    return 8'h19;
            4'd2:    return 8'h1A;
            4'd3:    return 8'h1B;
            default: return 8'h1C;
        endcase
    endfunction

    function automatic logic [7:0] init_val(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h07;
            4'd2:    return 8'h06;
            4'd3:    return 8'h18;
            default: return 8'h00;
        endcase
    endfunction

    // Pairing of issue/wait states for transfer and NACK reissue
    always_comb begin
        wait_st  = S_RD_WAIT;
        issue_st = S_RD_ISSUE;
        case (state)
            S_WHO_ISSUE, S_WHO_WAIT: begin
                wait_st  = S_WHO_WAIT;
                issue_st = S_WHO_ISSUE;
            end
            S_INIT_ISSUE, S_INIT_WAIT: begin
                wait_st  = S_INIT_WAIT;
                issue_st = S_INIT_ISSUE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk_12m) begin
        sample_valid <= 1'b0;
        if (rst) begin
            state <= S_PWRUP;
            pwr_cnt <= '0;
            samp_cnt <= '0;
            tmo_cnt <= '0;
            retry_cnt <= '0;
            idx <= '0;
            cmd_valid <= 1'b0;
            cmd_rw <= 1'b0;
            cmd_reg_addr <= '0;
            cmd_wdata <= '0;
            {accel_x, accel_y, accel_z, temp} <= '0;
            {gyro_x, gyro_y, gyro_z} <= '0;
            init_done <= 1'b0;
            err <= 1'b0;
            err_code <= 2'b00;
            overrun <= 1'b0;
        end else if (restart) begin
            state <= S_PWRUP;
            pwr_cnt <= '0;
            samp_cnt <= '0;
            tmo_cnt <= '0;
            retry_cnt <= '0;
            idx <= '0;
            cmd_valid <= 1'b0;
            init_done <= 1'b0;
            err <= 1'b0;
            err_code <= 2'b00;
            overrun <= 1'b0;
        end else begin
            if (init_done)
                samp_cnt <= tick ? '0 : samp_cnt + 32'd1;
            if (tick && (state == S_RD_ISSUE || state == S_RD_WAIT ||
                         state == S_PUBLISH))
                overrun <= 1'b1;
            case (state)
                S_PWRUP: begin
                    if (pwr_cnt == 32'(PWRUP_CYC - 1)) begin
                        pwr_cnt <= '0;
                        cmd_valid <= 1'b1;
                        cmd_wdata <= 8'h00;
`ifdef MPU_WHOAMI_CHECK_EN
                        state <= S_WHO_ISSUE;
                        cmd_rw <= 1'b1;
                        cmd_reg_addr <= 8'h75;
`else
                        state <= S_INIT_ISSUE;
                        idx <= 4'd0;
                        cmd_rw <= 1'b0;
                        cmd_reg_addr <= init_reg(4'd0);
                        cmd_wdata <= init_val(4'd0);
`endif
                    end else begin
                        pwr_cnt <= pwr_cnt + 32'd1;
                    end
                end
                S_WHO_ISSUE, S_INIT_ISSUE, S_RD_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        tmo_cnt <= '0;
                        state <= wait_st;
                    end
                end
                S_WHO_WAIT, S_INIT_WAIT, S_RD_WAIT: begin
                    if (rsp_valid && rsp_nack) begin
                        if (retry_cnt == RETRY_MAX[7:0]) begin
                            state <= S_ERROR;
                            err <= 1'b1;
                            err_code <= 2'b01;
                            init_done <= 1'b0;
                        end else begin
                            retry_cnt <= retry_cnt + 8'd1;
                            cmd_valid <= 1'b1;
                            state <= issue_st;
                        end
                    end else if (rsp_valid) begin
                        retry_cnt <= '0;
                        case (state)
`ifdef MPU_WHOAMI_CHECK_EN
                            S_WHO_WAIT: begin
                                if (rsp_data == 8'h68) begin
                                    state <= S_INIT_ISSUE;
                                    idx <= 4'd0;
                                    cmd_valid <= 1'b1;
                                    cmd_rw <= 1'b0;
                                    cmd_reg_addr <= init_reg(4'd0);
                                    cmd_wdata <= init_val(4'd0);
                                end else begin
                                    state <= S_ERROR;
                                    err <= 1'b1;
                                    err_code <= 2'b11;
                                end
                            end
`endif
                            S_INIT_WAIT: begin
                                if (idx == 4'd4) begin
                                    state <= S_IDLE;
                                    init_done <= 1'b1;
                                    samp_cnt <= '0;
                                end else begin
                                    state <= S_INIT_ISSUE;
                                    idx <= idx + 4'd1;
                                    cmd_valid <= 1'b1;
                                    cmd_reg_addr <= init_reg(idx + 4'd1);
                                    cmd_wdata <= init_val(idx + 4'd1);
                                end
                            end
                            default: begin
                                if (idx == 4'd13) begin
                                    // Last byte goes straight to gyro_z low
                                    state <= S_PUBLISH;
                                    sample_valid <= 1'b1;
                                    accel_x <= {shadow[0], shadow[1]};
                                    accel_y <= {shadow[2], shadow[3]};
                                    accel_z <= {shadow[4], shadow[5]};
                                    temp <= {shadow[6], shadow[7]};
                                    gyro_x <= {shadow[8], shadow[9]};
                                    gyro_y <= {shadow[10], shadow[11]};
                                    gyro_z <= {shadow[12], rsp_data};
                                end else begin
                                    shadow[idx] <= rsp_data;
                                    idx <= idx + 4'd1;
                                    state <= S_RD_ISSUE;
                                    cmd_valid <= 1'b1;
                                    cmd_reg_addr <= 8'h3C + {4'h0, idx};
                                end
                            end
                        endcase
                    end else if (tmo_cnt == 32'(TIMEOUT_CYC - 1)) begin
                        state <= S_ERROR;
                        err <= 1'b1;
                        err_code <= 2'b10;
                        init_done <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                S_IDLE: begin
                    if (tick) begin
                        state <= S_RD_ISSUE;
                        idx <= 4'd0;
                        cmd_valid <= 1'b1;
                        cmd_rw <= 1'b1;
                        cmd_reg_addr <= 8'h3B;
                        cmd_wdata <= 8'h00;
                    end
                end
                S_PUBLISH: state <= S_IDLE;
                default: begin
                    state <= S_ERROR;
                    cmd_valid <= 1'b0;
                    init_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mpu6050_seq_ctrl.md
MPU6050_SEQ_CTRL -- requirements
Module: mpu6050_seq_ctrl

Interface
REQ-001 Parameter DEV_ADDR, default 7'h68, MPU6050 7-bit slave address.
REQ-002 Parameter PWRUP_CYC, default 1200000, power-up wait in clocks (100 ms at 12 MHz).
REQ-003 Parameter SAMPLE_DIV, default 120000, sample period in clocks (100 Hz).
REQ-004 Parameter RETRY_MAX, default 3, NACK retries per command.
REQ-005 Parameter TIMEOUT_CYC, default 4095, response wait limit in clocks.
REQ-006 Port list (name, direction, width, meaning):
- sys_clk_12m, in, 1, the only clock.
- rst, in, 1, reset; synchronous, active-high.
- restart, in, 1, one-clock pulse that restarts from power-up wait.
- cmd_valid, out, 1, command request to the I2C engine.
- cmd_ready, in, 1, engine accepts the command.
- cmd_rw, out, 1, 1 = read, 0 = write.
- cmd_dev_addr, out, 7, slave address; always DEV_ADDR.
- cmd_reg_addr, out, 8, register address.
- cmd_wdata, out, 8, write data.
- rsp_valid, in, 1, one-clock completion pulse.
- rsp_nack, in, 1, NACK flag, qualified by rsp_valid.
- rsp_data, in, 8, read byte, qualified by rsp_valid.
- accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z, out, 16 each, signed sample words.
- sample_valid, out, 1, one-clock pulse when a new sample set is published.
- init_done, out, 1, initialisation complete.
- err, out, 1, sticky error flag.
- err_code, out, 2, error cause: 01 NACK, 10 timeout, 11 ID mismatch.
- overrun, out, 1, sticky flag for a missed sample tick.

Function
REQ-007 State machine: PWRUP -> [WHOAMI] -> INIT_ISSUE <-> INIT_WAIT -> IDLE -> RD_ISSUE <-> RD_WAIT -> PUBLISH -> IDLE; any state -> ERROR.
REQ-008 PWRUP counts PWRUP_CYC clocks with cmd_valid low, then advances.
REQ-009 The init table is written in this order: 0x6B<=0x00, 0x19<=0x07, 0x1A<=0x06, 0x1B<=0x18, 0x1C<=0x00.
REQ-010 Command handshake: a command transfers on the clock where cmd_valid and cmd_ready are both high.
REQ-011 cmd_valid and all cmd_* outputs hold stable from assertion until transfer.
REQ-012 cmd_valid drops the clock after transfer, and at most one command is outstanding.
REQ-013 After transfer, the block waits for rsp_valid; a rsp_valid outside a wait state is ignored.
REQ-014 On rsp_nack, the same command is reissued; after RETRY_MAX retries the block enters ERROR with err_code=01.
REQ-015 The timeout counter starts at transfer; reaching TIMEOUT_CYC without rsp_valid enters ERROR with err_code=10.
REQ-016 After the last init write, init_done goes high, and the sample counter starts from 0.
REQ-017 The sample counter wraps at SAMPLE_DIV-1 and generates a tick on wrap.
REQ-018 A tick in IDLE starts a read burst.
REQ-019 A tick during RD_ISSUE, RD_WAIT or PUBLISH sets overrun and is dropped; the counter keeps running.
REQ-020 Each burst issues 14 single-byte reads, registers 0x3B..0x48 ascending.
REQ-021 Read bytes fill a 14-byte shadow buffer; even offsets are the high byte, odd offsets the low byte.
REQ-022 PUBLISH copies the shadow buffer to the seven outputs in one clock and pulses sample_valid for exactly one clock.
REQ-023 Latency from the last rsp_valid of a burst to sample_valid is 1 clock.
REQ-024 A burst aborted by an error leaves the published outputs unchanged.
REQ-025 ERROR holds cmd_valid low and init_done low, and is exited only by rst or restart.
REQ-026 restart in any state clears err, err_code, overrun and init_done, then enters PWRUP.
REQ-027 The published sample outputs hold their values across restart.

Reset
REQ-028 On rst, state is PWRUP, and all counters are 0.
REQ-029 On rst, cmd_valid=0, cmd_rw=0, cmd_reg_addr=0, cmd_wdata=0, and cmd_dev_addr=DEV_ADDR.
REQ-030 On rst, all sample outputs are 0, and sample_valid, init_done, err and overrun are 0.
REQ-031 On rst, err_code=00.
REQ-032 rst mid-transaction abandons the transaction, and a later stale rsp_valid is ignored.
REQ-033 rst has priority over restart.

Configuration
REQ-034 Macro MPU_WHOAMI_CHECK_EN defined: after PWRUP, register 0x75 is read; data other than 0x68 enters ERROR with err_code=11; a match proceeds to INIT.
REQ-035 Macro MPU_WHOAMI_CHECK_EN undefined: PWRUP proceeds directly to INIT, and err_code=11 is never produced.

Verification
REQ-036 Reset release with cmd_ready=1 and a responder with a 5-clock rsp delay: the 5 init writes appear in REQ-009 order, then init_done=1.
REQ-037 Responder returns bytes 0x01..0x0E in order: one sample_valid pulse, accel_x=0x0102, gyro_z=0x0D0E.
REQ-038 NACK on the 0x1B write twice, then ACK: 3 issues of 0x1B, no error; NACK 4 times: err=1, err_code=01.
REQ-039 rsp_valid withheld for 4095 clocks: err=1, err_code=10; a restart pulse then reruns PWRUP and clears err.
REQ-040 Responder stalls each read by SAMPLE_DIV/10 clocks: overrun=1, and samples still publish correctly.
REQ-041 With MPU_WHOAMI_CHECK_EN defined, 0x75 returns 0x70: err_code=11 and no init writes are issued.
